// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 VGA timing constants and the mask row type.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Shared by the mask generator, the scanout block and its bench model.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Width of the pixel/line counters and of x_out/y_out.
    localparam int CNT_W = 10;

    // One mask row; index 0 is the leftmost pixel.
    typedef logic [0:VGA_H_ACTIVE-1] mask_row_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Purpose: horizontal/vertical raster counters advanced on the pixel tick.
// Latency: counters update one clk after a clk_en tick; line_end/next_line_active are combinational.
// Backpressure: none; free-running whenever clk_en is high.
// Ports: clk, rst (sync, active-high), clk_en -> h_cnt, v_cnt, line_end, next_line_active.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_end,
    output logic             next_line_active
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0] v_next;

    always_comb begin
        v_next           = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        // line_end is a tick-qualified strobe: the last pixel of a line on a live tick.
        line_end         = clk_en && (h_cnt == H_LAST);
        next_line_active = (v_next < V_ACT);
    end

    // Reset parks on the last line so the first displayed line is blanking,
    // giving the producer one full line to deliver row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= V_LAST;
        end else if (clk_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= v_next;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_row_scanout.sv
// Purpose: double-buffers mask rows from the mask generator and scans them out under VGA timing.
// Latency: output tuple is one pixel tick behind the raster counters; rows shown one line after capture.
// Backpressure: row_req high while the shadow is empty; rows offered into a full shadow are dropped (overrun).
// Ports: clk, rst, clk_en, mg_mask, rp_valid -> row_req, hsync, vsync, video_on, pixel_out,
//        x_out, y_out, underflow, overrun.
module mask_row_scanout
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [0:H_ACTIVE-1] mg_mask,
    input  logic                rp_valid,
    output logic                row_req,
    output logic                hsync,
    output logic                vsync,
    output logic                video_on,
    output logic                pixel_out,
    output logic [CNT_W-1:0]    x_out,
    output logic [CNT_W-1:0]    y_out,
    output logic                underflow,
    output logic                overrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int IDX_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]    h_cnt;
    logic [CNT_W-1:0]    v_cnt;
    logic                line_end;
    logic                next_line_active;
    logic                xfer;
    logic                vid_next;
    logic [IDX_W-1:0]    pix_idx;
    logic [0:H_ACTIVE-1] shadow;
    logic [0:H_ACTIVE-1] active;
    logic                shadow_full;

    vga_timing_counter #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .h_cnt            (h_cnt),
        .v_cnt            (v_cnt),
        .line_end         (line_end),
        .next_line_active (next_line_active)
    );

    always_comb begin
        // Shadow-to-active transfer on the last tick of the line preceding a visible line.
        xfer     = line_end && next_line_active;
        vid_next = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        // Keep the row index in range outside the active area.
        pix_idx  = vid_next ? h_cnt[IDX_W-1:0] : '0;
        row_req  = ~shadow_full;
    end

    // Row buffers and intake. Intake runs every clk; a transfer in the same
    // cycle frees the shadow, so a coincident row lands without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
            underflow   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (xfer) begin
                if (shadow_full) begin
                    active <= shadow;
                end else begin
                    active    <= '0;
                    underflow <= 1'b1;
                end
            end
            if (rp_valid && (!shadow_full || xfer)) begin
                shadow      <= mg_mask;
                shadow_full <= 1'b1;
            end else begin
                if (rp_valid) begin
                    overrun <= 1'b1;
                end
                if (xfer) begin
                    shadow_full <= 1'b0;
                end
            end
        end
    end

    // Output pipeline: one registered stage so the whole tuple describes the
    // same pixel, one tick behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out     <= '0;
            y_out     <= '0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            video_on  <= 1'b0;
            pixel_out <= 1'b0;
        end else if (clk_en) begin
            x_out     <= h_cnt;
            y_out     <= v_cnt;
            video_on  <= vid_next;
            pixel_out <= vid_next & active[pix_idx];
            hsync     <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync     <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_mask_row_scanout.sv
// Purpose: self-checking bench for mask_row_scanout on a scaled-down raster (24x10 ticks per frame).
// Latency: expects the output tuple one tick after the raster position it describes.
// Backpressure: exercises row_req, overrun on a full shadow, and underflow on a missing row.
module tb_mask_row_scanout;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;   // 24
    localparam int VT  = VA + VFP + VS + VBP;   // 10

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pix;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic [0:HA-1] mg_mask;
    logic          rp_valid;
    logic          row_req;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          pixel_out;
    logic [9:0]    x_out;
    logic [9:0]    y_out;
    logic          underflow;
    logic          overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   bh, bv, ph, pv;
    logic sb_on;
    exp_t sb[$];

    mask_row_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .mg_mask   (mg_mask),
        .rp_valid  (rp_valid),
        .row_req   (row_req),
        .hsync     (hsync),
        .vsync     (vsync),
        .video_on  (video_on),
        .pixel_out (pixel_out),
        .x_out     (x_out),
        .y_out     (y_out),
        .underflow (underflow),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (line %0d px %0d)", name, got, exp, pv, ph);
        end
    endtask

    // Scoreboard monitor: pops one expectation per visible pixel tuple.
    always @(posedge clk) begin : mon
        logic ce;
        exp_t e;
        ce = clk_en;
        #2;
        if (sb_on && ce && video_on) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: pixel x=%0d y=%0d shown with nothing expected", x_out, y_out);
            end else begin
                e = sb.pop_front();
                if (x_out !== e.x || y_out !== e.y || pixel_out !== e.pix) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d pix=%0d expected x=%0d y=%0d pix=%0d",
                             x_out, y_out, pixel_out, e.x, e.y, e.pix);
                end
            end
        end
    end

    // One clk cycle; tracks the raster position the next output tuple will describe.
    task automatic tick(input logic en, input logic rv, input logic [0:HA-1] m);
        clk_en   = en;
        rp_valid = rv;
        mg_mask  = m;
        @(posedge clk);
        #1;
        rp_valid = 1'b0;
        ph = bh;
        pv = bv;
        if (rst) begin
            bh = 0;
            bv = VT - 1;
        end else if (en) begin
            if (bh == HT - 1) begin
                bh = 0;
                bv = (bv == VT - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        sb.delete();
        rst = 1'b1;
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        rst = 1'b0;
    endtask

    task automatic push_row(input int y, input logic [0:HA-1] row);
        for (int x = 0; x < HA; x++) sb.push_back('{x: 10'(x), y: 10'(y), pix: row[x]});
    endtask

    function automatic logic [0:HA-1] mk_row(input int y);
        logic [0:HA-1] r;
        for (int x = 0; x < HA; x++) r[x] = ((x + y) % 3 == 0);
        return r;
    endfunction

    task automatic check_drain(input string name);
        #3;
        check(name, sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_hsync"}, hsync, 1);
        check({tag, "_vsync"}, vsync, 1);
        check({tag, "_video_on"}, video_on, 0);
        check({tag, "_pixel"}, pixel_out, 0);
        check({tag, "_row_req"}, row_req, 1);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [0:HA-1] alt;
        logic [0:HA-1] row_a;
        logic [0:HA-1] row_b;
        logic [0:HA-1] r;
        logic [23:0]   snap;
        int hs_cnt, vs_ticks, vid_total, vid_first;
        alt   = 16'hAAAA;
        row_a = 16'hC3A5;
        row_b = 16'h5A3C;
        rst = 1'b1; clk_en = 1'b0; rp_valid = 1'b0; mg_mask = '0; sb_on = 1'b0;
        bh = 0; bv = VT - 1; ph = 0; pv = 0;

        // Reset state, then a full frame with no rows.
        do_reset();
        check_reset_outputs("reset");
        for (int y = 0; y < VA; y++) push_row(y, '0);
        sb_on = 1'b1;
        hs_cnt = 0; vs_ticks = 0; vid_total = 0; vid_first = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick(1'b1, 1'b0, '0);
            if (i == 0) begin
                check("first_y", y_out, VT - 1);
                check("first_x", x_out, 0);
            end
            if (!hsync) hs_cnt++;
            if (!vsync) vs_ticks++;
            if (video_on) vid_total++;
            if (i < HT && video_on) vid_first++;
            if (i == HT - 2) check("underflow_before_xfer", underflow, 0);
            if (i == HT - 1) check("underflow_after_xfer", underflow, 1);
            if (ph == HT - 1) begin
                check("hsync_per_line", hs_cnt, HS);
                hs_cnt = 0;
            end
        end
        check("vsync_ticks", vs_ticks, VS * HT);
        check("video_on_total", vid_total, VA * HA);
        check("video_on_first_line", vid_first, 0);
        check_drain("drain_empty_frame");

        // Alternating row delivered during the reset line.
        do_reset();
        push_row(0, alt);
        sb_on = 1'b1;
        for (int i = 0; i < 2 * HT - 1; i++) begin
            if (i == 5) begin
                check("row_req_before_capture", row_req, 1);
                tick(1'b1, 1'b1, alt);
                check("row_req_after_capture", row_req, 0);
            end else begin
                tick(1'b1, 1'b0, '0);
            end
            if (i == HT - 1) check("row_req_after_xfer", row_req, 1);
        end
        check("alt_underflow", underflow, 0);
        check_drain("drain_alt");

        // Streamed distinct rows for a full frame.
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < HT * VT; i++) begin
            if (bh == 0 && ((bv + 1) % VT) < VA) begin
                r = mk_row((bv + 1) % VT);
                push_row((bv + 1) % VT, r);
                tick(1'b1, 1'b1, r);
            end else begin
                tick(1'b1, 1'b0, '0);
            end
        end
        check("stream_underflow", underflow, 0);
        check("stream_overrun", overrun, 0);
        check_drain("drain_stream");

        // Two rows in one line: the second is dropped.
        do_reset();
        push_row(0, row_a);
        sb_on = 1'b1;
        for (int i = 0; i < 2 * HT - 1; i++) begin
            if (i == 2)      tick(1'b1, 1'b1, row_a);
            else if (i == 6) tick(1'b1, 1'b1, row_b);
            else             tick(1'b1, 1'b0, '0);
            if (i == 2) check("overrun_after_first", overrun, 0);
            if (i == 6) check("overrun_after_second", overrun, 1);
        end
        check("overrun_sticky", overrun, 1);
        check_drain("drain_overrun");

        // Row offered on the transfer tick.
        do_reset();
        push_row(0, row_a);
        push_row(1, row_b);
        sb_on = 1'b1;
        for (int i = 0; i < 3 * HT - 1; i++) begin
            if (i == 3)           tick(1'b1, 1'b1, row_a);
            else if (i == HT - 1) tick(1'b1, 1'b1, row_b);
            else                  tick(1'b1, 1'b0, '0);
            if (i == HT - 1) begin
                check("row_req_coincident", row_req, 0);
                check("overrun_coincident", overrun, 0);
            end
        end
        check("coincident_overrun_end", overrun, 0);
        check("coincident_underflow_end", underflow, 0);
        check_drain("drain_coincident");

        // 1-of-4 pixel ticks, row captured on an idle cycle, reset mid-line 3.
        do_reset();
        while (!(bv == 3 && bh == 8)) begin
            tick(1'b1, 1'b0, '0);
            snap = {x_out, y_out, hsync, vsync, video_on, pixel_out};
            for (int k = 0; k < 3; k++) begin
                tick(1'b0, (bv == 3 && bh == 4 && k == 0), row_a);
                check("hold", {x_out, y_out, hsync, vsync, video_on, pixel_out}, snap);
            end
        end
        check("idle_capture_row_req", row_req, 0);
        check("pre_reset_underflow", underflow, 1);
        rst = 1'b1;
        tick(1'b0, 1'b0, '0);
        rst = 1'b0;
        check_reset_outputs("midline_reset");
        tick(1'b1, 1'b0, '0);
        check("post_reset_y", y_out, VT - 1);
        check("post_reset_x", x_out, 0);
        for (int i = 1; i < HT; i++) tick(1'b1, 1'b0, '0);
        check("dropped_row_underflow", underflow, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mask_row_scanout.md
Name: mask_row_scanout

Overview:
- Consumer end of the mask-generator row interface.
- Accepts 640-bit mask rows (`mg_mask` + `rp_valid`) from the mask generator and double-buffers them.
- Serializes each row pixel-by-pixel under standard 640x480@60 VGA timing and requests the next row as soon as its shadow buffer frees up.
- Sits between the mask generator and the VGA pin driver.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  pixel tick; counters, buffers-to-active transfer and outputs advance only when high
- mg_mask  in  [0:H_ACTIVE-1]  mask row; bit 0 = leftmost pixel (x=0)
- rp_valid  in  1  one-cycle strobe, mg_mask valid
- row_req  out  1  level, high while shadow buffer empty
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  pixel tuple is inside active area
- pixel_out  out  1  mask bit for current pixel, 0 outside active area
- x_out  out  10  pixel column of current output tuple
- y_out  out  10  line number of current output tuple
- underflow  out  1  sticky: active line started with no row available
- overrun  out  1  sticky: row offered while shadow full (row dropped)

Behaviour:
- Reset is synchronous and active-high: `rst` high at a `clk` edge clears state that cycle.
  - h_cnt=0, v_cnt=V_TOTAL-1 (524), so the first line is blanking and the producer gets one full line to deliver row 0.
  - shadow_full=0, active buffer=0, underflow=overrun=0.
  - hsync=vsync=~SYNC_POL, video_on=0, pixel_out=0, x_out=y_out=0.
- Reset mid-line drops all buffered rows; no flags are set by reset itself.
- H_TOTAL = 800 and V_TOTAL = 525 (sums of the parameters).
- On each clk_en tick, h_cnt increments and wraps at H_TOTAL-1 to 0. On that wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
- Row intake is independent of clk_en and evaluated every clk cycle:
  - If rp_valid and the shadow is empty (including the same-cycle transfer case below), capture mg_mask and set shadow_full.
  - If rp_valid and the shadow stays full, drop mg_mask and set overrun.
- Row transfer occurs on a clk_en tick where h_cnt=H_TOTAL-1 and the next v_cnt < V_ACTIVE:
  - If shadow_full: active <= shadow and shadow_full <= 0.
  - If the shadow is empty: active <= 0 and underflow <= 1.
- Simultaneous transfer and rp_valid in the same cycle: the transfer takes the old shadow, the new row lands in the shadow, shadow_full stays 1, and no overrun.
- row_req = ~shadow_full, combinational from a register.
- Output stage is one registered pipeline stage, updated on clk_en only. The tuple (x_out, y_out, hsync, vsync, video_on, pixel_out) always describes one pixel, one tick after the counters.
  - video_on = (h<640 && v<480).
  - pixel_out = video_on ? active[h] : 0.
  - hsync = SYNC_POL when 656 <= h < 752.
  - vsync = SYNC_POL when 490 <= v < 492.
- With clk_en low, all outputs hold; intake still operates.
- underflow and overrun clear only on rst.

Decomposition:
- Package `vga_timing_pkg`:
  - H/V active, porch and sync constants.
  - Derived H_TOTAL/V_TOTAL.
  - `mask_row_t` = logic [0:639].
  - Shared with the generator and the bench golden model.
- One sub-module, `vga_timing_counter`:
  - Takes clk, rst, clk_en.
  - Produces h_cnt, v_cnt, line_end and next_line_active.
  - Reusable by other VGA blocks.
- Row buffers, intake and output pipeline stay in the top module.

Test Plan:
- Reset then 800×525 clk_en ticks with no rows → exactly 96 hsync-asserted ticks per line, 2 vsync lines per frame, video_on=0 for line 524, and underflow=1 after the first active-line transfer.
- Deliver a row 0xAAAA… (alternating, bit0=1) during reset line 524 → on line y_out=0, pixel_out toggles 1,0,1,… for x_out 0..639, and row_req drops after capture and reasserts after transfer.
- Stream a distinct row each line (bit x = x mod 3 == 0 for row 0, shifted by y per row) for a full frame → bench compares all 307200 pixels, with underflow=0 and overrun=0.
- Send two rp_valid strobes within one line with no transfer between them → the second is dropped, overrun=1, and the first row's content is displayed.
- rp_valid coincident with the transfer tick → the old row is displayed next line, the new row is held in the shadow, and overrun stays 0.
- clk_en at 1-of-4 duty, with rst asserted mid-line 100 → outputs hold between ticks; after reset, h=0, v=524, buffers are empty, and flags are cleared.
